// File: rtl/etc_pkg.sv
// Shared definitions for the extended tensor core and its output stages.
package etc_pkg;

  localparam int ETC_W = 16;

  typedef logic [3:0][3:0][ETC_W-1:0] tile_t;

  // Zero selects plain MMA (add); any other value selects the min semiring.
  localparam logic [1:0] OP_MMA = 2'd0;

endpackage

// File: rtl/etc_reduce_elem.sv
// Single-element combine: add (wrap, or saturate under ETC_ACC_SAT_EN) or unsigned min.
module etc_reduce_elem
  import etc_pkg::*;
#(
  parameter int W = ETC_W
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r
);

  logic [W:0]   sumFull;
  logic [W-1:0] sumRes;
  logic [W-1:0] minRes;

  // Carry-out of the add feeds the optional saturation.
  always_comb begin
    sumFull = {1'b0, a} + {1'b0, b};
`ifdef ETC_ACC_SAT_EN
    sumRes  = sumFull[W] ? {W{1'b1}} : sumFull[W-1:0];
`else
    sumRes  = sumFull[W-1:0];
`endif
    minRes  = (a < b) ? a : b;
    r       = (op == OP_MMA) ? sumRes : minRes;
  end

endmodule

// File: rtl/etc_tile_accum.sv
// Output-side tile accumulator: folds a group of K 4x4 tiles into one result,
// element-wise add or min, and returns it on a valid/ready port.
// Optional macro ETC_ACC_SAT_EN: add mode saturates instead of wrapping.
module etc_tile_accum
  import etc_pkg::*;
#(
  parameter int W = ETC_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                op,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [3:0][3:0][W-1:0]    in_tile,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0][3:0][W-1:0]    out_tile,
  output logic [7:0]                out_beats
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state, stateNext;
  logic [3:0][3:0][W-1:0]   acc, reduced, accNext;
  logic [1:0]               opQ;
  logic [7:0]               beatCnt, beatNext;
  logic                     accept, firstBeat;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign firstBeat = (state == IDLE);

  // One combiner per element, always fed by the group's latched op.
  for (genvar i = 0; i < 4; i++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_col
      etc_reduce_elem #(.W(W)) u_elem (
        .op (opQ),
        .a  (acc[i][j]),
        .b  (in_tile[i][j]),
        .r  (reduced[i][j])
      );
    end
  end

  // First beat of a group loads straight through; later beats combine.
  always_comb begin
    accNext  = firstBeat ? in_tile : reduced;
    beatNext = firstBeat ? 8'd1 : ((beatCnt == 8'hFF) ? 8'hFF : beatCnt + 8'd1);
  end

  // Next-state: a last beat always closes the group, otherwise a beat opens/keeps it.
  always_comb begin
    stateNext = state;
    if (accept) stateNext = in_last ? IDLE : ACCUM;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Accumulator, latched op and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      opQ     <= OP_MMA;
      beatCnt <= '0;
    end else if (accept) begin
      acc     <= accNext;
      beatCnt <= beatNext;
      if (firstBeat) opQ <= op;
    end
  end

  // Output register: a new result overrides a draining one, else drain clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_tile  <= '0;
      out_beats <= '0;
    end else if (accept && in_last) begin
      out_valid <= 1'b1;
      out_tile  <= accNext;
      out_beats <= beatNext;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
